// File: rtl/multi_operand_adder_pipe.sv
// Pipelined multi-operand adder: a balanced binary tree of carry-lookahead adders,
// one register stage per tree level, with valid/ready handshakes on both sides.

module carry_lookahead_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] g_s;
    logic [W-1:0] p_s;
    logic [W:0]   c_s;

    assign g_s = a_i & b_i;
    assign p_s = a_i ^ b_i;

    // Each carry is expanded from the generate/propagate terms of all lower bits,
    // so no carry depends on a previously computed carry.
    always_comb begin
        logic pp;
        logic cy;
        pp     = 1'b1;
        cy     = 1'b0;
        c_s    = {(W+1){1'b0}};
        c_s[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            pp = 1'b1;
            cy = 1'b0;
            for (int j = i; j >= 0; j--) begin
                cy = cy | (g_s[j] & pp);
                pp = pp & p_s[j];
            end
            c_s[i+1] = cy | (cin_i & pp);
        end
    end

    assign sum_o  = p_s ^ c_s[W-1:0];
    assign cout_o = c_s[W];

endmodule

module multi_operand_adder_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 4,
    parameter int SIGNED  = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]           in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH+$clog2(NUM_OPS)-1:0]   out_sum
);

    localparam int LEVELS = $clog2(NUM_OPS);

    // Bit offset of registered level k inside the flat stage vector; level k holds
    // NUM_OPS>>k values of WIDTH+k bits each.
    function automatic int lvl_base(input int k);
        int b;
        b = 0;
        for (int j = 1; j < k; j++) begin
            b = b + (NUM_OPS >> j) * (WIDTH + j);
        end
        return b;
    endfunction

    localparam int TOT = lvl_base(LEVELS + 1);

    logic             adv_s;
    logic [LEVELS:1]  v_q;
    logic [LEVELS:1]  v_d;
    logic [TOT-1:0]   stage_q;
    logic [TOT-1:0]   stage_d;

    // The whole pipe moves together: it stalls only when the last stage is full and blocked.
    assign adv_s    = ~v_q[LEVELS] | out_ready;
    assign in_ready = adv_s;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        for (genvar n = 0; n < (NUM_OPS >> k); n++) begin : g_node
            logic [WIDTH+k-2:0] x_s;
            logic [WIDTH+k-2:0] y_s;
            logic [WIDTH+k-1:0] sx_s;
            logic [WIDTH+k-1:0] sy_s;
            logic [WIDTH+k-1:0] sum_s;
            logic               cout_unused;

            if (k == 1) begin : g_src_in
                assign x_s = in_data[(2*n)*WIDTH +: WIDTH];
                assign y_s = in_data[(2*n+1)*WIDTH +: WIDTH];
            end else begin : g_src_stage
                assign x_s = stage_q[lvl_base(k-1) + (2*n)*(WIDTH+k-1) +: (WIDTH+k-1)];
                assign y_s = stage_q[lvl_base(k-1) + (2*n+1)*(WIDTH+k-1) +: (WIDTH+k-1)];
            end

            // One guard bit per level keeps the sum exact in both signedness modes.
            assign sx_s = {((SIGNED != 0) & x_s[WIDTH+k-2]), x_s};
            assign sy_s = {((SIGNED != 0) & y_s[WIDTH+k-2]), y_s};

            carry_lookahead_adder #(.W(WIDTH+k)) u_cla (
                .a_i    (sx_s),
                .b_i    (sy_s),
                .cin_i  (1'b0),
                .sum_o  (sum_s),
                .cout_o (cout_unused)
            );

            assign stage_d[lvl_base(k) + n*(WIDTH+k) +: (WIDTH+k)] = sum_s;
        end
    end

    // Next valid bits: shift one level on advance, otherwise hold.
    always_comb begin
        v_d = v_q;
        if (adv_s) begin
            v_d[1] = in_valid;
            for (int k = 2; k <= LEVELS; k++) begin
                v_d[k] = v_q[k-1];
            end
        end else begin
            v_d = v_q;
        end
    end

    // Pipeline valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= {LEVELS{1'b0}};
        end else begin
            v_q <= v_d;
        end
    end

    // Pipeline data; empty stages load whatever the tree produces, which is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {TOT{1'b0}};
        end else if (adv_s) begin
            stage_q <= stage_d;
        end else begin
            stage_q <= stage_q;
        end
    end

    assign out_valid = v_q[LEVELS];
    assign out_sum   = stage_q[lvl_base(LEVELS) +: (WIDTH+LEVELS)];

endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Scoreboard bench for multi_operand_adder_pipe: three configurations (32x4 unsigned,
// 8x8 signed, 1x2 unsigned) checked against arithmetic reference sums.

module tb_multi_operand_adder_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    bit  lat_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_in_data;
    logic [33:0]  a_out_sum;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0]  b_in_data;
    logic [10:0]  b_out_sum;
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [1:0]   c_in_data;
    logic [1:0]   c_out_sum;

    multi_operand_adder_pipe #(.WIDTH(32), .NUM_OPS(4), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum));
    multi_operand_adder_pipe #(.WIDTH(8), .NUM_OPS(8), .SIGNED(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum));
    multi_operand_adder_pipe #(.WIDTH(1), .NUM_OPS(2), .SIGNED(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_sum(c_out_sum));

    function automatic logic [33:0] model_a(input logic [127:0] d);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) s = s + longint'(d[i*32 +: 32]);
        return s[33:0];
    endfunction

    function automatic logic [10:0] model_b(input logic [63:0] d);
        int s;
        logic signed [7:0] o;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            o = d[i*8 +: 8];
            s = s + int'(o);
        end
        return s[10:0];
    endfunction

    function automatic logic [1:0] model_c(input logic [1:0] d);
        int s;
        s = int'(d[0]) + int'(d[1]);
        return s[1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [33:0] a_exp_q[$];  int a_cyc_q[$];  bit a_stall = 1'b0;  logic [33:0] a_held;
    logic [10:0] b_exp_q[$];  int b_cyc_q[$];  bit b_stall = 1'b0;  logic [10:0] b_held;
    logic [1:0]  c_exp_q[$];  int c_cyc_q[$];  bit c_stall = 1'b0;  logic [1:0]  c_held;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_exp_q.delete(); a_cyc_q.delete(); a_stall = 1'b0;
        end else begin
            if (a_stall) begin
                chk("a_stall_valid", 64'(a_out_valid), 64'd1);
                chk("a_stall_hold", 64'(a_out_sum), 64'(a_held));
            end
            chk("a_in_ready", 64'(a_in_ready), 64'(!(a_out_valid && !a_out_ready)));
            if (a_out_valid && a_out_ready) begin
                if (a_exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL a_unexpected: got %0h, expected no output", a_out_sum);
                end else begin
                    chk("a_sum", 64'(a_out_sum), 64'(a_exp_q.pop_front()));
                    if (lat_chk) chk("a_latency", 64'(cyc - a_cyc_q.pop_front()), 64'd2);
                    else void'(a_cyc_q.pop_front());
                end
            end
            if (a_in_valid && a_in_ready) begin
                a_exp_q.push_back(model_a(a_in_data)); a_cyc_q.push_back(cyc);
            end
            a_stall = a_out_valid && !a_out_ready;
            a_held  = a_out_sum;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_exp_q.delete(); b_cyc_q.delete(); b_stall = 1'b0;
        end else begin
            if (b_stall) begin
                chk("b_stall_valid", 64'(b_out_valid), 64'd1);
                chk("b_stall_hold", 64'(b_out_sum), 64'(b_held));
            end
            chk("b_in_ready", 64'(b_in_ready), 64'(!(b_out_valid && !b_out_ready)));
            if (b_out_valid && b_out_ready) begin
                if (b_exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL b_unexpected: got %0h, expected no output", b_out_sum);
                end else begin
                    chk("b_sum", 64'(b_out_sum), 64'(b_exp_q.pop_front()));
                    if (lat_chk) chk("b_latency", 64'(cyc - b_cyc_q.pop_front()), 64'd3);
                    else void'(b_cyc_q.pop_front());
                end
            end
            if (b_in_valid && b_in_ready) begin
                b_exp_q.push_back(model_b(b_in_data)); b_cyc_q.push_back(cyc);
            end
            b_stall = b_out_valid && !b_out_ready;
            b_held  = b_out_sum;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            c_exp_q.delete(); c_cyc_q.delete(); c_stall = 1'b0;
        end else begin
            if (c_stall) begin
                chk("c_stall_valid", 64'(c_out_valid), 64'd1);
                chk("c_stall_hold", 64'(c_out_sum), 64'(c_held));
            end
            chk("c_in_ready", 64'(c_in_ready), 64'(!(c_out_valid && !c_out_ready)));
            if (c_out_valid && c_out_ready) begin
                if (c_exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL c_unexpected: got %0h, expected no output", c_out_sum);
                end else begin
                    chk("c_sum", 64'(c_out_sum), 64'(c_exp_q.pop_front()));
                    if (lat_chk) chk("c_latency", 64'(cyc - c_cyc_q.pop_front()), 64'd1);
                    else void'(c_cyc_q.pop_front());
                end
            end
            if (c_in_valid && c_in_ready) begin
                c_exp_q.push_back(model_c(c_in_data)); c_cyc_q.push_back(cyc);
            end
            c_stall = c_out_valid && !c_out_ready;
            c_held  = c_out_sum;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    endtask

    initial begin
        a_in_data = 128'd0; b_in_data = 64'd0; c_in_data = 2'd0;
        idle();
        rst_n = 1'b0;
        step(); step();
        chk("rst_a_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_sum", 64'(a_out_sum), 64'd0);
        chk("rst_a_ready", 64'(a_in_ready), 64'd1);
        chk("rst_b_valid", 64'(b_out_valid), 64'd0);
        chk("rst_b_sum", 64'(b_out_sum), 64'd0);
        chk("rst_b_ready", 64'(b_in_ready), 64'd1);
        chk("rst_c_valid", 64'(c_out_valid), 64'd0);
        chk("rst_c_sum", 64'(c_out_sum), 64'd0);
        chk("rst_c_ready", 64'(c_in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // Unsigned all-ones, two-stage latency.
        a_in_valid = 1'b1; a_in_data = {4{32'hFFFF_FFFF}};
        step();
        a_in_valid = 1'b0;
        chk("a_ones_early", 64'(a_out_valid), 64'd0);
        step();
        chk("a_ones_valid", 64'(a_out_valid), 64'd1);
        chk("a_ones_sum", 64'(a_out_sum), 64'h3_FFFF_FFFC);
        step(); step();

        // Signed corner sums, three-stage latency.
        b_in_valid = 1'b1; b_in_data = {8{8'h80}};
        step();
        b_in_valid = 1'b0;
        step();
        chk("b_neg_early", 64'(b_out_valid), 64'd0);
        step();
        chk("b_neg_valid", 64'(b_out_valid), 64'd1);
        chk("b_neg_sum", 64'(b_out_sum), 64'h400);
        b_in_valid = 1'b1; b_in_data = {48'd0, 8'hFF, 8'h7F};
        step();
        b_in_valid = 1'b0;
        step(); step();
        chk("b_mix_sum", 64'(b_out_sum), 64'd126);
        step(); step();

        // Minimum configuration, all input combinations, one-cycle latency.
        for (int i = 0; i < 4; i++) begin
            c_in_valid = 1'b1; c_in_data = 2'(i);
            step();
            chk("c_min_valid", 64'(c_out_valid), 64'd1);
            chk("c_min_sum", 64'(c_out_sum), 64'((i & 1) + (i >> 1)));
        end
        c_in_valid = 1'b0;
        step(); step();

        // Random traffic under pseudo-random backpressure on every instance.
        lat_chk = 1'b0;
        for (int i = 0; i < 60; i++) begin
            a_in_valid = 1'($urandom_range(0, 1));
            a_in_data  = {$urandom, $urandom, $urandom, $urandom};
            a_out_ready = 1'($urandom_range(0, 1));
            b_in_valid = 1'($urandom_range(0, 1));
            b_in_data  = {$urandom, $urandom};
            b_out_ready = 1'($urandom_range(0, 1));
            c_in_valid = 1'($urandom_range(0, 1));
            c_in_data  = 2'($urandom);
            c_out_ready = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        for (int i = 0; i < 8; i++) step();
        lat_chk = 1'b1;

        // Full-rate streaming: operand i of set c is c+i.
        for (int c = 0; c <= 20; c++) begin
            a_in_valid = (c < 20);
            for (int i = 0; i < 4; i++) a_in_data[i*32 +: 32] = 32'(c + i);
            step();
            if (c >= 1) begin
                chk("a_stream_valid", 64'(a_out_valid), 64'd1);
                chk("a_stream_sum", 64'(a_out_sum), 64'(4 * (c - 1) + 6));
            end
        end
        idle();
        step(); step();

        // Reset while two signed sets are still inside the tree.
        b_in_valid = 1'b1; b_in_data = {$urandom, $urandom};
        step();
        b_in_data = {$urandom, $urandom};
        step();
        b_in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("b_flushed", 64'(b_out_valid), 64'd0);
        end
        b_in_valid = 1'b1; b_in_data = {$urandom, $urandom};
        step();
        b_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        chk("a_drained", 64'(a_exp_q.size()), 64'd0);
        chk("b_drained", 64'(b_exp_q.size()), 64'd0);
        chk("c_drained", 64'(c_exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_operand_adder_pipe.md
# multi_operand_adder_pipe

Parametrised, pipelined multi-operand adder that sums NUM_OPS operands of WIDTH bits each through a balanced binary tree of carry_lookahead_adder nodes. There is one register stage per tree level. Operands enter and results leave over valid/ready handshakes, and results are never lost under backpressure. It supersedes the fixed, combinational 4x32 chained adder in the datapath library for use wherever operand count, width or signedness vary or a clocked, throttleable path is needed.

## Interface
- WIDTH, 32: operand width in bits; must be ≥ 1.
- NUM_OPS, 4: operand count; must be a power of two and ≥ 2.
- SIGNED, 0: 0 treats operands as unsigned (zero-extend); 1 treats them as two's complement (sign-extend).
- LEVELS (localparam), $clog2(NUM_OPS): tree depth, equal to pipeline latency.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_data holds a valid operand set.
- in_ready, output, 1: the block accepts in_data this cycle.
- in_data, input, NUM_OPS*WIDTH: operand i is in bits [i*WIDTH +: WIDTH].
- out_valid, output, 1: out_sum holds a valid result.
- out_ready, input, 1: downstream accepts out_sum this cycle.
- out_sum, output, WIDTH+LEVELS: sum of all NUM_OPS operands.

## Operation
- Tree structure:
  - Level k (1..LEVELS) holds NUM_OPS>>k adder nodes.
  - Each node adds two level-(k-1) values of width WIDTH+k-1, each extended by 1 bit (zero or sign per SIGNED), with cin=0.
  - Each node produces a WIDTH+k result. The cout port is unused.
  - Level k's result is stored in a stage-k register together with a valid bit v[k].
- Width rule: the final width WIDTH+LEVELS is exact. Overflow is impossible in either mode. In signed mode, out_sum is two's complement.
- Global advance enable: adv = !v[LEVELS] || out_ready.
  - in_ready = adv. This is combinational; there is no dependency of in_ready on in_valid.
  - When adv=1, every stage shifts one level: stage 1 ← level-1 sums of in_data, v[1] ← in_valid, and stage k ← level-k sums of stage k-1, v[k] ← v[k-1].
  - When adv=0, all stages and valid bits hold their values.
- Outputs: out_valid = v[LEVELS], and out_sum is the stage-LEVELS register.
- in_data is sampled only on an accepted cycle (in_valid && in_ready). Stage data registers may load don't-care values when the corresponding valid bit is 0.
- Bubbles are not collapsed. An empty stage still advances only with adv.
- Ordering: results emerge strictly in acceptance order. There is no reordering and no drop.

## Timing
- Reset (rst_n=0, asynchronous assert, synchronous-safe release):
  - All v[k] = 0 and all stage data = 0.
  - out_valid = 0 and out_sum = 0.
  - in_ready = 1 while out_valid = 0.
- Reset mid-operation: all in-flight results are discarded. No partial result appears after release.
- Latency: an operand set accepted at edge t appears with out_valid=1 after edge t+LEVELS-1 (LEVELS register stages), given no stall.
  - NUM_OPS=2 gives 1 cycle.
  - NUM_OPS=4 gives 2 cycles.
- Throughput: one result per cycle while out_ready=1.
- Simultaneous events: out_valid && out_ready in the same cycle as in_valid gives a full-rate handover. The output and input transfer on the same edge.
- Stall: with out_valid=1 and out_ready=0, in_ready=0 and out_sum is held stable until it is accepted.
- Empty pipeline with out_ready=0: adv=1, so the pipeline keeps filling until the last stage holds valid data.

## Test plan
- Reset and unsigned sum: WIDTH=32, NUM_OPS=4, SIGNED=0, rst_n pulsed low → out_valid=0, out_sum=0, in_ready=1. Then operands FFFFFFFF ×4 with out_ready=1 → exactly 2 cycles later out_valid=1 and out_sum=0x3_FFFF_FFFC.
- Signed sum: SIGNED=1, WIDTH=8, NUM_OPS=8, operands {-128 ×8} → out_sum=11'h400 (-1024) after 3 cycles. Operands {127,-1,0,…,0} → out_sum=126.
- Backpressure: stream 10 random operand sets with out_ready toggled pseudo-randomly (50%) → every result matches the reference sum in order, with no duplicates or drops. out_sum stays stable while out_valid && !out_ready. in_ready=0 exactly when out_valid && !out_ready.
- Full throughput: in_valid=1 and out_ready=1 for 20 cycles, operand i = cycle index + i → 20 consecutive results with no bubbles, each equal to NUM_OPS*cycle + NUM_OPS*(NUM_OPS-1)/2.
- Reset mid-flight: accept 2 sets, then assert rst_n low for 1 cycle before either emerges → neither result is ever presented. After release, the next accepted set yields the correct sum.
- Minimum configuration: NUM_OPS=2, WIDTH=1, all four {a,b} combinations → out_sum = a+b (2 bits) with 1-cycle latency.
